uart_rx_fifo: RTL

- Parametrised UART receiver with a built-in receive FIFO; successor to the fixed 8N1 single-byte-handshake receiver.
- Adds programmable 5–8 data bits, even/odd parity, glitch-rejecting start detection, break detection, per-entry error flags, sticky error status and an idle-timeout flag.
- Sits between the board UART pins (uart_txd_in, pio26) and the peripheral bus register block.

---
 rtl/uart_rx_fifo_pkg.sv | 16 +
 rtl/uart_sync_fifo.sv | 45 ++++
 rtl/uart_rx_fifo.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// uart_pkg: shared FSM states, data-bit encodings, flag/error indices and the data-bit count helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} state_e;
  localparam logic [1:0] BITS_5 = 2'b00;
  localparam logic [1:0] BITS_6 = 2'b01;
  localparam logic [1:0] BITS_7 = 2'b10;
  localparam logic [1:0] BITS_8 = 2'b11;
  localparam int FLAG_FRAME = 0;
  localparam int FLAG_PARITY = 1;
  localparam int ERR_FRAME = 0;
  localparam int ERR_PARITY = 1;
  localparam int ERR_OVERRUN = 2;
  function automatic logic [3:0] nbits(input logic [1:0] b);
    return 4'd5 + {2'b00, b};
  endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: synchronous FIFO (push_i/data_i in, pop_i/data_o out, full_o, empty_o, level_o; sysclk, async active-low rst)
module uart_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [LW-1:0] level_q, level_d;
  logic wr, rd;
  always_comb begin
    full_o = level_q == LW'(DEPTH);
    empty_o = level_q == '0;
    wr = push_i && (!full_o || pop_i);
    rd = pop_i && !empty_o;
    wp_d = wp_q + AW'(wr);
    rp_d = rp_q + AW'(rd);
    level_d = level_q + LW'(wr) - LW'(rd);
    level_o = level_q;
    data_o = empty_o ? '0 : mem_q[rp_q];
  end
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      wp_q <= '0;
      rp_q <= '0;
      level_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      level_q <= level_d;
    end
  end
  always_ff @(posedge sysclk) if (wr) mem_q[wp_q] <= data_i;
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: configurable UART receiver (5-8 bits, parity, break, timeout) feeding a receive FIFO; rx_i/cfg_* in, rx_*/level/err/break/timeout/busy out
module uart_rx_fifo import uart_pkg::*; #(
  parameter int DIV_W = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int SYNC_STAGES = 2,
  parameter int IDLE_CHARS = 4,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic             rx_i,
  input  logic             cfg_en_i,
  input  logic [DIV_W-1:0] cfg_div_i,
  input  logic [1:0]       cfg_bits_i,
  input  logic             cfg_parity_en_i,
  input  logic             cfg_parity_odd_i,
  output logic [7:0]       rx_data_o,
  output logic [1:0]       rx_flags_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  output logic [LW-1:0]    level_o,
  output logic [2:0]       err_o,
  input  logic             err_clr_i,
  output logic             break_o,
  output logic             timeout_o,
  output logic             busy_o
);
  localparam int TW = DIV_W + 5 + $clog2(IDLE_CHARS);
  state_e state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic rx_s, rx_prev_q;
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
  logic [1:0] bits_q, bits_d;
  logic par_en_q, par_en_d, par_odd_q, par_odd_d, par_bit_q, par_bit_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] data_q, data_d;
  logic [2:0] err_q, err_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d, tmo_lim;
  logic tmo_q, tmo_d;
  logic start_det, tick, last_bit, par_err, frame_err, is_break, push, pop, full, empty, tmo_clr;
  logic [9:0] fifo_dout;
  always_comb begin
    rx_s = sync_q[SYNC_STAGES-1];
    sync_d = (sync_q << 1) | SYNC_STAGES'(rx_i);
    start_det = state_q == IDLE && cfg_en_i && rx_prev_q && !rx_s;
    tick = cnt_q == '0;
    last_bit = {1'b0, bit_q} == nbits(bits_q) - 4'd1;
    par_err = par_en_q && ((^data_q ^ par_bit_q) != par_odd_q);
    frame_err = !rx_s;
    is_break = frame_err && data_q == '0 && !(par_en_q && par_bit_q);
    pop = rx_ready_i && !empty;
  end
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (start_det) state_d = START;
      START:      if (tick) state_d = rx_s ? IDLE : DATA;
      DATA:       if (tick && last_bit) state_d = par_en_q ? PARITY : STOP;
      PARITY:     if (tick) state_d = STOP;
      STOP:       if (tick) state_d = is_break ? BREAK_WAIT : IDLE;
      BREAK_WAIT: if (rx_s) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
    if (!cfg_en_i) state_d = IDLE;
  end
  always_comb begin
    push = state_q == STOP && tick && cfg_en_i && !is_break;
    break_o = state_q == STOP && tick && cfg_en_i && is_break;
    busy_o = state_q != IDLE;
  end
  always_comb begin
    cnt_d = start_det ? (cfg_div_i >> 1) - DIV_W'(1) : state_q == IDLE ? cnt_q : tick ? div_q - DIV_W'(1) : cnt_q - DIV_W'(1);
    div_d = start_det ? cfg_div_i : div_q;
    bits_d = start_det ? cfg_bits_i : bits_q;
    par_en_d = start_det ? cfg_parity_en_i : par_en_q;
    par_odd_d = start_det ? cfg_parity_odd_i : par_odd_q;
    par_bit_d = (state_q == PARITY && tick) ? rx_s : par_bit_q;
    bit_d = start_det ? 3'd0 : (state_q == DATA && tick) ? bit_q + 3'd1 : bit_q;
    data_d = start_det ? 8'h00 : data_q;
    if (state_q == DATA && tick) data_d[bit_q] = rx_s;
    err_d = err_clr_i ? 3'b000 : err_q;
    err_d[ERR_OVERRUN] = err_d[ERR_OVERRUN] | (push && full && !pop);
    err_d[ERR_PARITY] = err_d[ERR_PARITY] | (push && par_err);
    err_d[ERR_FRAME] = err_d[ERR_FRAME] | (push && frame_err);
    tmo_lim = TW'(IDLE_CHARS) * TW'(nbits(bits_q) + {3'b000, par_en_q} + 4'd2) * TW'(div_q);
    tmo_clr = pop || start_det || empty;
    tmo_cnt_d = tmo_clr ? '0 : (state_q == IDLE && !tmo_q) ? tmo_cnt_q + TW'(1) : tmo_cnt_q;
    tmo_d = tmo_clr ? 1'b0 : tmo_q || (state_q == IDLE && tmo_cnt_q + TW'(1) == tmo_lim);
  end
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
      rx_prev_q <= 1'b1;
      cnt_q <= '0;
      div_q <= '0;
      bits_q <= '0;
      par_en_q <= 1'b0;
      par_odd_q <= 1'b0;
      par_bit_q <= 1'b0;
      bit_q <= '0;
      data_q <= '0;
      err_q <= '0;
      tmo_cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      rx_prev_q <= rx_s;
      cnt_q <= cnt_d;
      div_q <= div_d;
      bits_q <= bits_d;
      par_en_q <= par_en_d;
      par_odd_q <= par_odd_d;
      par_bit_q <= par_bit_d;
      bit_q <= bit_d;
      data_q <= data_d;
      err_q <= err_d;
      tmo_cnt_q <= tmo_cnt_d;
      tmo_q <= tmo_d;
    end
  end
  uart_sync_fifo #(.WIDTH(10), .DEPTH(FIFO_DEPTH)) u_fifo (
    .sysclk  (sysclk),
    .rst     (rst),
    .push_i  (push),
    .data_i  ({par_err, frame_err, data_q}),
    .pop_i   (pop),
    .data_o  (fifo_dout),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level_o)
  );
  always_comb begin
    rx_valid_o = !empty;
    rx_data_o = fifo_dout[7:0];
    rx_flags_o = {fifo_dout[8+FLAG_PARITY], fifo_dout[8+FLAG_FRAME]};
    err_o = err_q;
    timeout_o = tmo_q;
  end
endmodule
